// File: rtl/ysyx_22040759_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit and its alignment helper.
package ysyx_22040759_lsu_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned OFF_W = 3;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Writeback error codes
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ACCESS   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [XLEN-1:0] MEM_BASE_DFLT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Memory-port request payload, held stable while mem_req waits for a grant
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] wmask;
  } mem_req_t;

  // Unshifted bit mask of the byte lanes touched by an access of the given size
  function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] size);
    logic [XLEN-1:0] m;
    case (size)
      F3_SB[1:0]: m = 64'h0000_0000_0000_00FF;
      F3_SH[1:0]: m = 64'h0000_0000_0000_FFFF;
      F3_SW[1:0]: m = 64'h0000_0000_FFFF_FFFF;
      default:    m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Byte-lane alignment: store data/mask placement, load extraction/extension, misalignment.
module ysyx_22040759_lsu_align
  import ysyx_22040759_lsu_pkg::*;
(
  input  logic [2:0]       func3_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  wmask_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic             misaligned_o
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] rshift;

  assign shamt   = {offset_i, 3'b000};
  assign wdata_o = wdata_i << shamt;
  assign wmask_o = lane_mask(func3_i[1:0]) << shamt;
  assign rshift  = rdata_i >> shamt;

  // Natural alignment check by access size
  always_comb begin
    misaligned_o = 1'b0;
    case (func3_i[1:0])
      2'b00:   misaligned_o = 1'b0;
      2'b01:   misaligned_o = offset_i[0];
      2'b10:   misaligned_o = |offset_i[1:0];
      default: misaligned_o = |offset_i;
    endcase
  end

  // Sign/zero extension of the right-aligned load data
  always_comb begin
    rdata_o = '0;
    case (func3_i)
      F3_LB:   rdata_o = {{56{rshift[7]}},  rshift[7:0]};
      F3_LH:   rdata_o = {{48{rshift[15]}}, rshift[15:0]};
      F3_LW:   rdata_o = {{32{rshift[31]}}, rshift[31:0]};
      F3_LD:   rdata_o = rshift;
      F3_LBU:  rdata_o = {56'd0, rshift[7:0]};
      F3_LHU:  rdata_o = {48'd0, rshift[15:0]};
      F3_LWU:  rdata_o = {32'd0, rshift[31:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_lsu.sv
// MEM-stage load/store initiator driving the data-memory request port.
module ysyx_22040759_lsu
  import ysyx_22040759_lsu_pkg::*;
#(
  parameter int unsigned     RESP_TIMEOUT = 255,
  parameter logic [XLEN-1:0] MEM_BASE     = MEM_BASE_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic            lsu_wen,
  input  logic [2:0]      lsu_func3,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_rdata,
  output logic [1:0]      wb_err,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       func3_q, func3_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             wen_q, wen_d;
  mem_req_t         mem_q, mem_d;
  logic             mem_req_q, mem_req_d;
  logic             lsu_ready_q, lsu_ready_d;
  logic             wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]  wb_rdata_q, wb_rdata_d;
  logic [1:0]       wb_err_q, wb_err_d;

  logic [2:0]       al_func3;
  logic [OFF_W-1:0] al_off;
  logic [XLEN-1:0]  al_wdata, al_wmask, al_rdata;
  logic             al_mis;
  logic [1:0]       acc_err;
  logic             wait_to;

  // Incoming request is decoded in IDLE; afterwards the latched access drives extraction
  assign al_func3 = (state_q == ST_IDLE) ? lsu_func3 : func3_q;
  assign al_off   = (state_q == ST_IDLE) ? lsu_addr[2:0] : off_q;
  assign wait_to  = (cnt_q == CNT_W'(RESP_TIMEOUT - 1));

  ysyx_22040759_lsu_align u_align (
    .func3_i      (al_func3),
    .offset_i     (al_off),
    .wdata_i      (lsu_wdata),
    .rdata_i      (mem_rdata),
    .wdata_o      (al_wdata),
    .wmask_o      (al_wmask),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  // Access legality in priority order: address range, funct3 legality, alignment
  always_comb begin
    acc_err = ERR_OK;
    if (lsu_addr < MEM_BASE) begin
      acc_err = ERR_ACCESS;
    end else if (lsu_wen ? lsu_func3[2] : (lsu_func3 == 3'b111)) begin
      acc_err = ERR_ACCESS;
    end else if (al_mis) begin
      acc_err = ERR_MISALIGN;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and timeout counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (lsu_valid) begin
          state_d = (acc_err == ERR_OK) ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (wen_q || mem_rvalid) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid || wait_to) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; handshake outputs decode the upcoming state
  always_comb begin
    func3_d     = func3_q;
    off_d       = off_q;
    wen_d       = wen_q;
    mem_d       = mem_q;
    wb_rdata_d  = wb_rdata_q;
    wb_err_d    = wb_err_q;
    lsu_ready_d = (state_d == ST_IDLE);
    mem_req_d   = (state_d == ST_REQ);
    wb_valid_d  = (state_d == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid) begin
          func3_d    = lsu_func3;
          off_d      = lsu_addr[2:0];
          wen_d      = lsu_wen;
          wb_rdata_d = '0;
          wb_err_d   = acc_err;
          if (acc_err == ERR_OK) begin
            mem_d.we    = lsu_wen;
            mem_d.addr  = {lsu_addr[XLEN-1:3], 3'b000};
            mem_d.wdata = lsu_wen ? al_wdata : '0;
            mem_d.wmask = lsu_wen ? al_wmask : '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt && !wen_q && mem_rvalid) begin
          wb_rdata_d = al_rdata;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          wb_rdata_d = al_rdata;
        end else if (wait_to) begin
          wb_err_d = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and latched access fields
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      func3_q     <= '0;
      off_q       <= '0;
      wen_q       <= 1'b0;
      mem_q       <= '0;
      mem_req_q   <= 1'b0;
      lsu_ready_q <= 1'b1;
      wb_valid_q  <= 1'b0;
      wb_rdata_q  <= '0;
      wb_err_q    <= ERR_OK;
    end else begin
      cnt_q       <= cnt_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      wen_q       <= wen_d;
      mem_q       <= mem_d;
      mem_req_q   <= mem_req_d;
      lsu_ready_q <= lsu_ready_d;
      wb_valid_q  <= wb_valid_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign lsu_ready = lsu_ready_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rdata  = wb_rdata_q;
  assign wb_err    = wb_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_q.we;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign mem_wmask = mem_q.wmask;

endmodule

// File: tb/tb_ysyx_22040759_lsu.sv
// Scoreboard bench for the MEM-stage LSU: memory responder, writeback monitor, directed stimulus.
module tb_ysyx_22040759_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_wen = 1'b0;
  logic [2:0]  lsu_func3 = 3'd0;
  logic [63:0] lsu_addr = 64'd0;
  logic [63:0] lsu_wdata = 64'd0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [63:0] wb_rdata;
  logic [1:0]  wb_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  always #5 clk = ~clk;

  ysyx_22040759_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_wen    (lsu_wen),
    .lsu_func3  (lsu_func3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rdata   (wb_rdata),
    .wb_err     (wb_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  err;
  } wb_exp_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } mem_exp_t;

  wb_exp_t  wq[$];
  mem_exp_t mq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // responder / writeback behaviour knobs set by the stimulus
  int          gnt_wait = 0;
  int          wb_stall = 0;
  bit          rv_same = 1'b0;
  bit          rv_never = 1'b0;
  bit          inject_rv = 1'b0;
  logic [63:0] rd_word = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder: checks each request cycle against the queue head, grants after gnt_wait
  initial begin : responder
    int gcnt = 0;
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rst) begin
        gcnt = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          mem_rvalid = 1'b1;
          pend       = 1'b0;
        end else if (inject_rv) begin
          mem_rvalid = 1'b1;
          inject_rv  = 1'b0;
        end
        if (mem_req) begin
          if (mq.size() == 0) begin
            chk("mem_req_unexpected", 64'(mem_req), 64'd0);
          end else begin
            chk("mem_we",    64'(mem_we), 64'(mq[0].we));
            chk("mem_addr",  mem_addr,  mq[0].addr);
            chk("mem_wdata", mem_wdata, mq[0].wdata);
            chk("mem_wmask", mem_wmask, mq[0].wmask);
            if (gcnt < gnt_wait) begin
              gcnt++;
            end else begin
              gcnt    = 0;
              mem_gnt = 1'b1;
              if (!mem_we && !rv_never) begin
                if (rv_same) mem_rvalid = 1'b1;
                else         pend = 1'b1;
              end
              void'(mq.pop_front());
            end
          end
        end
      end
      mem_rdata = mem_rvalid ? rd_word : 64'h5A5A_A5A5_5A5A_A5A5;
    end
  end

  // writeback monitor: compares while valid (stability during stalls), pops on handshake
  initial begin : wb_monitor
    int scnt = 0;
    forever begin
      @(negedge clk);
      if (wb_valid && !rst) begin
        chk("lsu_ready_busy", 64'(lsu_ready), 64'd0);
        if (wq.size() == 0) begin
          chk("wb_valid_unexpected", 64'(wb_valid), 64'd0);
          wb_ready = 1'b1;
        end else begin
          chk("wb_rdata", wb_rdata, wq[0].rdata);
          chk("wb_err", 64'(wb_err), 64'(wq[0].err));
          if (scnt < wb_stall) begin
            wb_ready = 1'b0;
            scnt++;
          end else begin
            wb_ready = 1'b1;
            scnt     = 0;
            void'(wq.pop_front());
          end
        end
      end else begin
        wb_ready = 1'b1;
      end
    end
  end

  task automatic run(input string name, input logic wen, input logic [2:0] f3,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] exp_rd, input logic [1:0] exp_err, input int exp_lat,
                     input logic [63:0] m_wdata, input logic [63:0] m_wmask);
    bit has_mem;
    int lat;
    int k;
    logic [63:0] aaddr;
    has_mem = (exp_err == 2'b00) || (exp_err == 2'b11);
    aaddr   = {addr[63:3], 3'b000};
    if (has_mem) mq.push_back('{we: wen, addr: aaddr, wdata: m_wdata, wmask: m_wmask});
    wq.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    chk({name, "/lsu_ready"}, 64'(lsu_ready), 64'd1);
    lsu_valid = 1'b1;
    lsu_wen   = wen;
    lsu_func3 = f3;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    @(negedge clk);
    lsu_valid = 1'b0;
    lsu_wen   = 1'b0;
    lsu_addr  = 64'd0;
    lsu_wdata = 64'd0;
    if (!has_mem) chk({name, "/no_mem_req"}, 64'(mem_req), 64'd0);
    lat = 1;
    while (!wb_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "/latency"}, 64'(lat), 64'(exp_lat));
    k = 0;
    while (wb_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, "/wb_release"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/lsu_ready", 64'(lsu_ready), 64'd1);
    chk("rst/wb_valid",  64'(wb_valid), 64'd0);
    chk("rst/wb_rdata",  wb_rdata, 64'd0);
    chk("rst/wb_err",    64'(wb_err), 64'd0);
    chk("rst/mem_req",   64'(mem_req), 64'd0);
    chk("rst/mem_we",    64'(mem_we), 64'd0);
    chk("rst/mem_addr",  mem_addr, 64'd0);
    chk("rst/mem_wdata", mem_wdata, 64'd0);
    chk("rst/mem_wmask", mem_wmask, 64'd0);

    // loads with each extension flavour
    rd_word = 64'h0000_0000_8000_0000;
    run("lb",  1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 3, 64'd0, 64'd0);
    rd_word = 64'h1111_1111_1111_117F;
    run("lb_pos", 1'b0, 3'b000, 64'h8000_0000, 64'd0, 64'h0000_0000_0000_007F, 2'b00, 3, 64'd0, 64'd0);
    rd_word = 64'hF000_0000_0000_0000;
    run("lbu", 1'b0, 3'b100, 64'h8000_0007, 64'd0, 64'h0000_0000_0000_00F0, 2'b00, 3, 64'd0, 64'd0);
    rd_word = 64'h8765_4321_0000_0000;
    run("lwu", 1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'h0000_0000_8765_4321, 2'b00, 3, 64'd0, 64'd0);

    // stores of every size
    run("sh", 1'b1, 3'b001, 64'h8000_0006, 64'h1234_ABCD, 64'd0, 2'b00, 2,
        64'hABCD_0000_0000_0000, 64'hFFFF_0000_0000_0000);
    run("sb", 1'b1, 3'b000, 64'h8000_0001, 64'h1122_3344_5566_77AA, 64'd0, 2'b00, 2,
        64'h2233_4455_6677_AA00, 64'h0000_0000_0000_FF00);
    run("sd", 1'b1, 3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b00, 2,
        64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);

    // errors: alignment, funct3 legality, address range, priority
    run("lw_mis", 1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 2'b01, 1, 64'd0, 64'd0);
    run("ld_mis", 1'b0, 3'b011, 64'h8000_0004, 64'd0, 64'd0, 2'b01, 1, 64'd0, 64'd0);
    run("lh_mis", 1'b0, 3'b001, 64'h8000_0003, 64'd0, 64'd0, 2'b01, 1, 64'd0, 64'd0);
    run("sd_mis", 1'b1, 3'b011, 64'h8000_000C, 64'd1, 64'd0, 2'b01, 1, 64'd0, 64'd0);
    run("st_f3", 1'b1, 3'b100, 64'h8000_0000, 64'h55, 64'd0, 2'b10, 1, 64'd0, 64'd0);
    run("st_f3_mis", 1'b1, 3'b101, 64'h8000_0001, 64'h55, 64'd0, 2'b10, 1, 64'd0, 64'd0);
    run("ld_f3", 1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 2'b10, 1, 64'd0, 64'd0);
    run("ld_low", 1'b0, 3'b011, 64'h7FFF_FFF8, 64'd0, 64'd0, 2'b10, 1, 64'd0, 64'd0);
    run("lw_low_mis", 1'b0, 3'b010, 64'h7FFF_FFFF, 64'd0, 64'd0, 2'b10, 1, 64'd0, 64'd0);

    // grant held off five cycles: request fields checked every stalled cycle
    gnt_wait = 5;
    run("sw_gnt_stall", 1'b1, 3'b010, 64'h8000_0014, 64'hDEAD_BEEF, 64'd0, 2'b00, 7,
        64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_0000_0000);
    gnt_wait = 0;

    // writeback held off three cycles
    wb_stall = 3;
    rd_word  = 64'h0000_0000_8001_0000;
    run("lh_wb_stall", 1'b0, 3'b001, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_8001, 2'b00, 3, 64'd0, 64'd0);
    wb_stall = 0;
    run("lhu", 1'b0, 3'b101, 64'h8000_0002, 64'd0, 64'h0000_0000_0000_8001, 2'b00, 3, 64'd0, 64'd0);

    // rvalid in the grant cycle
    rv_same = 1'b1;
    rd_word = 64'h8765_4321_0000_0000;
    run("lw_same_cycle", 1'b0, 3'b010, 64'h8000_0004, 64'd0, 64'hFFFF_FFFF_8765_4321, 2'b00, 2, 64'd0, 64'd0);
    rv_same = 1'b0;

    // timeout after 255 silent WAIT cycles, then a stray rvalid in IDLE
    rv_never = 1'b1;
    run("lwu_timeout", 1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'd0, 2'b11, 257, 64'd0, 64'd0);
    rv_never  = 1'b0;
    rd_word   = 64'hFFFF_FFFF_FFFF_FFFF;
    inject_rv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_rv/wb_valid",  64'(wb_valid), 64'd0);
      chk("late_rv/lsu_ready", 64'(lsu_ready), 64'd1);
    end

    // reset while waiting for read data
    rv_never = 1'b1;
    mq.push_back('{we: 1'b0, addr: 64'h8000_0010, wdata: 64'd0, wmask: 64'd0});
    @(negedge clk);
    lsu_valid = 1'b1;
    lsu_wen   = 1'b0;
    lsu_func3 = 3'b011;
    lsu_addr  = 64'h8000_0010;
    @(negedge clk);
    lsu_valid = 1'b0;
    k = 0;
    while (mq.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_wait/granted", 64'(mq.size()), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait/lsu_ready", 64'(lsu_ready), 64'd1);
    chk("rst_wait/mem_req",   64'(mem_req), 64'd0);
    chk("rst_wait/wb_valid",  64'(wb_valid), 64'd0);
    rv_never = 1'b0;
    rd_word  = 64'hCAFE_F00D_1234_5678;
    run("ld_after_rst", 1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'hCAFE_F00D_1234_5678, 2'b00, 3, 64'd0, 64'd0);

    repeat (2) @(negedge clk);
    chk("wb_queue_drained",  64'(wq.size()), 64'd0);
    chk("mem_queue_drained", 64'(mq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
